// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the rr_arbiter8 round-robin arbiter.
package rr_arb_pkg;
  localparam int RR_N      = 8;
  localparam int RR_IDX_W  = 3;
  localparam int RR_HOLD_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } rr_state_e;
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and rr_arbiter8 (slave).
interface rr_arbiter8_if;
  import rr_arb_pkg::*;

  logic [RR_N-1:0]     req;
  logic [RR_N-1:0]     gnt;
  logic [RR_IDX_W-1:0] gnt_idx;
  logic                gnt_valid;
  logic                timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_dec3x8.sv
// Combinational 3-bit index to 8-bit one-hot decoder.
module rr_dec3x8
  import rr_arb_pkg::*;
(
  input  logic [RR_IDX_W-1:0] i_idx,
  output logic [RR_N-1:0]     o_onehot
);
  for (genvar gi = 0; gi < RR_N; gi++) begin : g_dec
    assign o_onehot[gi] = (i_idx == RR_IDX_W'(gi));
  end
endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and owner index.
// Optional grant watchdog is built when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter8_if.slave bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 2..255");
  end

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 8.
  function automatic logic [RR_IDX_W:0] rr_pick(
    input logic [RR_N-1:0]     vec,
    input logic [RR_IDX_W-1:0] start
  );
    logic [RR_IDX_W:0]   res;
    logic [RR_IDX_W-1:0] idx;
    res = '0;
    for (int k = RR_N - 1; k >= 0; k--) begin
      idx = start + RR_IDX_W'(k);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  rr_state_e           r_state;
  rr_state_e           w_state_next;
  logic [RR_N-1:0]     r_gnt;
  logic [RR_N-1:0]     w_gnt_next;
  logic [RR_IDX_W-1:0] r_gnt_idx;
  logic [RR_IDX_W-1:0] w_gnt_idx_next;
  logic                r_gnt_valid;
  logic                w_gnt_valid_next;
  logic                r_timeout;
  logic                w_timeout_next;
  logic [RR_IDX_W-1:0] r_ptr;
  logic [RR_IDX_W-1:0] w_ptr_next;

  logic                w_release;
  logic                w_timeout_hit;
  logic                w_arb;
  logic [RR_N-1:0]     w_masked;
  logic [RR_IDX_W:0]   w_pick;
  logic                w_found;
  logic [RR_IDX_W-1:0] w_win;
  logic [RR_N-1:0]     w_win_onehot;

  assign w_release = (r_state == ST_GRANT) && !bus.req[r_gnt_idx];
  assign w_arb     = (r_state == ST_IDLE) || w_release || w_timeout_hit;
  // On a watchdog revoke the owner is excluded so the grant must move or go idle.
  assign w_masked  = w_timeout_hit ? (bus.req & ~r_gnt) : bus.req;
  assign w_pick    = rr_pick(w_masked, r_ptr);
  assign w_found   = w_pick[RR_IDX_W];
  assign w_win     = w_pick[RR_IDX_W-1:0];

  rr_dec3x8 u_dec (
    .i_idx    (w_win),
    .o_onehot (w_win_onehot)
  );

`ifdef RR_ARB_TIMEOUT_EN
  logic [RR_HOLD_W-1:0] r_hold;
  logic [RR_HOLD_W-1:0] w_hold_next;

  assign w_timeout_hit = (r_state == ST_GRANT) && bus.req[r_gnt_idx] &&
                         (r_hold == RR_HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    w_hold_next = r_hold;
    if (w_arb && w_found) begin
      w_hold_next = '0;
    end else if (r_state == ST_GRANT && r_hold != '1) begin
      w_hold_next = r_hold + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hold <= '0;
    else        r_hold <= w_hold_next;
  end
`else
  assign w_timeout_hit = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_gnt       <= w_gnt_next;
      r_gnt_idx   <= w_gnt_idx_next;
      r_gnt_valid <= w_gnt_valid_next;
      r_timeout   <= w_timeout_next;
      r_ptr       <= w_ptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_arb) w_state_next = w_found ? ST_GRANT : ST_IDLE;
  end

  always_comb begin
    w_gnt_next       = r_gnt;
    w_gnt_idx_next   = r_gnt_idx;
    w_gnt_valid_next = r_gnt_valid;
    w_ptr_next       = r_ptr;
    w_timeout_next   = w_timeout_hit;
    if (w_arb) begin
      if (w_found) begin
        w_gnt_next       = w_win_onehot;
        w_gnt_idx_next   = w_win;
        w_gnt_valid_next = 1'b1;
        w_ptr_next       = w_win + 1'b1;
      end else begin
        w_gnt_next       = '0;
        w_gnt_valid_next = 1'b0;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed table-driven bench for rr_arbiter8; timeout checks follow RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter8;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic et);
    n_vec++;
    if (bus.gnt !== eg || bus.gnt_idx !== ei || bus.gnt_valid !== ev || bus.timeout !== et) begin
      n_err++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
               name, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, eg, ei, ev, et);
    end else begin
      $display("ok   %s: req=%h gnt=%h idx=%0d valid=%b timeout=%b",
               name, bus.req, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout);
    end
  endtask

  task automatic step(input logic [7:0] r);
    @(negedge clk);
    bus.req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Rotation, pointer wrap/skip, idle return, hold without preemption.
    tbl[0]  = '{8'hFE, 8'h02, 3'd1, 1'b1};
    tbl[1]  = '{8'hFD, 8'h04, 3'd2, 1'b1};
    tbl[2]  = '{8'hFB, 8'h08, 3'd3, 1'b1};
    tbl[3]  = '{8'hF7, 8'h10, 3'd4, 1'b1};
    tbl[4]  = '{8'hEF, 8'h20, 3'd5, 1'b1};
    tbl[5]  = '{8'hDF, 8'h40, 3'd6, 1'b1};
    tbl[6]  = '{8'hBF, 8'h80, 3'd7, 1'b1};
    tbl[7]  = '{8'h7F, 8'h01, 3'd0, 1'b1};
    tbl[8]  = '{8'hFF, 8'h01, 3'd0, 1'b1};
    tbl[9]  = '{8'h40, 8'h40, 3'd6, 1'b1};
    tbl[10] = '{8'h09, 8'h01, 3'd0, 1'b1};
    tbl[11] = '{8'h08, 8'h08, 3'd3, 1'b1};
    tbl[12] = '{8'h00, 8'h00, 3'd3, 1'b0};
    tbl[13] = '{8'h18, 8'h10, 3'd4, 1'b1};
    tbl[14] = '{8'h04, 8'h04, 3'd2, 1'b1};
    tbl[15] = '{8'h24, 8'h04, 3'd2, 1'b1};
    tbl[16] = '{8'h24, 8'h04, 3'd2, 1'b1};
    tbl[17] = '{8'h20, 8'h20, 3'd5, 1'b1};
    tbl[18] = '{8'h00, 8'h00, 3'd5, 1'b0};

    bus.req = 8'hFF;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 check("reset_held", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].req);
      check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].valid, 1'b0);
    end

    // Long hold by owner 1 with requester 4 waiting.
    step(8'h02);
    check("grant1", 8'h02, 3'd1, 1'b1, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step(8'h12);
      check($sformatf("hold1_%0d", i), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    step(8'h12);
    check("to_handover", 8'h10, 3'd4, 1'b1, 1'b1);
    step(8'h12);
    check("to_pulse_end", 8'h10, 3'd4, 1'b1, 1'b0);
    step(8'h02);
    check("regrant1", 8'h02, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'h02);
      check($sformatf("solo_hold_%0d", i), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    step(8'h02);
    check("to_idle", 8'h00, 3'd1, 1'b0, 1'b1);
    step(8'h02);
    check("to_regrant", 8'h02, 3'd1, 1'b1, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      step(8'h12);
      check($sformatf("hold1_%0d", i), 8'h02, 3'd1, 1'b1, 1'b0);
    end
`endif

    // Reset while a grant is held, then pointer must restart at 0.
    step(8'h30);
    check("pre_reset", 8'h10, 3'd4, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_grant", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus.req = 8'h21;
    rst_n   = 1'b1;
    @(posedge clk);
    #1 check("post_reset_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
